uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 140 ++++++++++++++
 tb/tb_uart_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter fed by a small circular byte FIFO.
// TX is taken straight from bit 0 of the frame shift register, which idles all-ones.
module uart_tx #(
  parameter int BAUD  = 2604,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  output logic       busy,
  output logic       full,
  output logic       empty
);

  localparam int                PTR_W     = $clog2(DEPTH);
  localparam int                CNT_W     = PTR_W + 1;
  localparam int                BAUD_W    = (BAUD > 1) ? $clog2(BAUD) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD - 1);
  localparam logic [3:0]        LAST_BIT  = 4'd9;
  localparam logic [0:0]        IDLE      = 1'b0;
  localparam logic [0:0]        TRANSMIT  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [9:0]        shift_q, shift_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic              done_q, done_d;
  logic [7:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q;
  logic              push_s, pop_s;

  // full is the registered flag, so a push coinciding with a pop while full is dropped
  assign push_s = trmt & ~full_q;
  assign pop_s  = (state_q == IDLE) & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          state_d = TRANSMIT;
          shift_d = {1'b1, mem_q[rd_ptr_q], 1'b0};
          baud_d  = {BAUD_W{1'b0}};
          bit_d   = 4'd0;
        end else begin
          shift_d = 10'h3FF;
        end
      end
      TRANSMIT: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = {BAUD_W{1'b0}};
          if (bit_q == LAST_BIT) begin
            state_d = IDLE;
            shift_d = 10'h3FF;
            done_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = {1'b1, shift_q[9:1]};
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = 10'h3FF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= 10'h3FF;
      baud_q   <= {BAUD_W{1'b0}};
      bit_q    <= 4'd0;
      done_q   <= 1'b0;
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
      empty_q  <= (count_d == {CNT_W{1'b0}});
      if (push_s) begin
        mem_q[wr_ptr_q] <= tx_data;
      end
    end
  end

  assign TX      = shift_q[0];
  assign tx_done = done_q;
  assign busy    = (state_q == TRANSMIT);
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at BAUD=16, DEPTH=4.
// Accepted bytes are queued when driven; a serial monitor decodes TX and pops them.
module tb_uart_tx;

  localparam int BAUD  = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trmt;
  logic [7:0] tx_data;
  logic       TX, tx_done, busy, full, empty;

  int         n_vec = 0;
  int         n_err = 0;
  int         frames_seen = 0;
  int         done_cnt = 0;
  bit         b2b_pending = 1'b0;
  logic [7:0] exp_q[$];

  uart_tx #(.BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data),
    .TX(TX), .tx_done(tx_done), .busy(busy), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, required %0h", tag, got, exp);
    end
  endtask

  task automatic drive_push(input logic [7:0] b, input bit accept);
    tx_data = b;
    trmt    = 1'b1;
    if (accept) exp_q.push_back(b);
    @(negedge clk);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int c;
    c = 0;
    while (frames_seen < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_eq("frames_done", frames_seen, target);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Serial monitor: decode each frame at mid-bit and check frame-end timing
  initial begin : monitor
    logic [9:0] bits;
    logic [7:0] exp_b;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (b2b_pending) begin
        check_eq("b2b_start", TX, 1'b0);
        b2b_pending = 1'b0;
      end
      if (rst_n === 1'b1 && TX === 1'b0) begin
        bits    = 10'h000;
        aborted = 1'b0;
        for (int k = 0; k <= 160; k++) begin
          if (k > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (k % BAUD == BAUD / 2) bits[k / BAUD] = TX;
          if (k == 159) begin
            check_eq("busy_last_cycle", busy, 1'b1);
            check_eq("done_early", tx_done, 1'b0);
          end
          if (k == 160) begin
            check_eq("done_pulse", tx_done, 1'b1);
            check_eq("busy_gap", busy, 1'b0);
            check_eq("tx_idle_after", TX, 1'b1);
          end
        end
        if (!aborted) begin
          frames_seen++;
          check_eq("start_bit", bits[0], 1'b0);
          check_eq("stop_bit", bits[9], 1'b1);
          check_eq("sb_nonempty", (exp_q.size() > 0), 1'b1);
          if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            check_eq("frame_byte", bits[8:1], exp_b);
          end
          b2b_pending = (exp_q.size() > 0);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int c;
    int base_done;
    int lows;
    rst_n   = 1'b0;
    trmt    = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", TX, 1'b1);
    check_eq("rst_done", tx_done, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_full", full, 1'b0);
    check_eq("rst_empty", empty, 1'b1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_tx", TX, 1'b1);

    // single byte, latency of one cycle from push to start bit
    drive_push(8'hA5, 1'b1);
    trmt = 1'b0;
    check_eq("lat_pre_tx", TX, 1'b1);
    check_eq("lat_pre_empty", empty, 1'b0);
    @(negedge clk);
    check_eq("lat_fall_tx", TX, 1'b0);
    check_eq("lat_busy", busy, 1'b1);
    check_eq("lat_empty", empty, 1'b1);
    wait_frames(1, 400);
    check_eq("done_cnt_1", done_cnt, 1);

    // three back-to-back frames
    repeat (5) @(negedge clk);
    drive_push(8'h00, 1'b1);
    drive_push(8'hFF, 1'b1);
    drive_push(8'h3C, 1'b1);
    trmt = 1'b0;
    wait_frames(4, 800);
    check_eq("b2b_empty", empty, 1'b1);
    check_eq("b2b_busy", busy, 1'b0);
    check_eq("done_cnt_4", done_cnt, 4);

    // overfill, then a push while full in the pop cycle
    repeat (5) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      drive_push(8'h10 + 8'(i), (i < 5));
    end
    trmt = 1'b0;
    check_eq("full_after_fill", full, 1'b1);
    c = 0;
    while (tx_done !== 1'b1 && c < 300) begin
      @(negedge clk);
      c++;
    end
    check_eq("done_before_marker", tx_done, 1'b1);
    check_eq("full_at_frame_end", full, 1'b1);
    tx_data = 8'hEE;
    trmt    = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    check_eq("pop_while_full_full", full, 1'b0);
    check_eq("pop_while_full_empty", empty, 1'b0);
    wait_frames(9, 1000);
    check_eq("done_cnt_9", done_cnt, 9);
    check_eq("fill_empty", empty, 1'b1);

    // reset in the middle of data bit 4 with two bytes queued
    repeat (5) @(negedge clk);
    drive_push(8'h00, 1'b1);
    drive_push(8'h11, 1'b1);
    drive_push(8'h22, 1'b1);
    trmt = 1'b0;
    repeat (84) @(negedge clk);
    check_eq("bit4_low", TX, 1'b0);
    base_done = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_tx", TX, 1'b1);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_empty", empty, 1'b1);
    check_eq("arst_done", tx_done, 1'b0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (TX !== 1'b1) lows++;
    end
    check_eq("no_frame_after_rst", lows, 0);
    check_eq("no_done_after_rst", done_cnt, base_done);
    check_eq("post_rst_empty", empty, 1'b1);

    // block works again after reset
    drive_push(8'h5A, 1'b1);
    trmt = 1'b0;
    wait_frames(10, 400);
    check_eq("done_after_recover", done_cnt, base_done + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
